// File: rtl/ascii_hex_pkg.sv
// Shared definitions for the ASCII hex word parser: FSM encoding, terminator
// characters and error codes.
package ascii_hex_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2,
    ST_SKIP  = 2'd3
  } state_e;

  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_COMMA = 8'h2C;

  localparam logic [1:0] ERR_NONE         = 2'b00;
  localparam logic [1:0] ERR_INVALID      = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW     = 2'b10;
  localparam logic [1:0] ERR_EMPTY_PREFIX = 2'b11;

endpackage

// File: rtl/ascii_hex_char_class.sv
// Combinational classifier: splits an ASCII character into hex digit,
// word terminator or the prefix letter x/X, and extracts the digit value.
module ascii_hex_char_class
  import ascii_hex_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_digit,
  output logic       is_term,
  output logic       is_x,
  output logic [3:0] nibble
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    is_digit = 1'b0;
    nibble   = 4'h0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      is_digit = 1'b1;
      nibble   = ch[3:0];
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so letters map to low nibble + 9.
      is_digit = 1'b1;
      nibble   = ch[3:0] + 4'd9;
    end
  end

  assign is_term = (ch == CHAR_CR) || (ch == CHAR_LF) ||
                   (ch == CHAR_SPACE) || (ch == CHAR_COMMA);
  assign is_x    = (ch == 8'h78) || (ch == 8'h58);

endmodule

// File: rtl/ascii_hex_word_parser.sv
// Streams ASCII characters in, emits right-justified hex words with a
// valid/ready handshake. Optional "0x" prefix support: ASCII_HEX_PREFIX_EN.
module ascii_hex_word_parser
  import ascii_hex_pkg::*;
#(
  parameter  int NUM_DIGITS = 8,
  localparam int WORD_WIDTH = 4 * NUM_DIGITS,
  localparam int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ascii_valid,
  input  logic [7:0]            ascii_data,
  output logic                  ascii_ready,
  output logic                  word_valid,
  output logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_ready,
  output logic [CNT_W-1:0]      digit_count,
  output logic                  err_pulse,
  output logic [1:0]            err_code
);

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_pulse_q, err_pulse_d;
  logic [1:0]            err_code_q, err_code_d;
`ifdef ASCII_HEX_PREFIX_EN
  logic                  prefix_q, prefix_d;
`endif

  logic       is_digit, is_term, is_x;
  logic [3:0] nibble;
  logic       accept;

  ascii_hex_char_class u_char_class (
    .ch       (ascii_data),
    .is_digit (is_digit),
    .is_term  (is_term),
    .is_x     (is_x),
    .nibble   (nibble)
  );

`ifndef ASCII_HEX_PREFIX_EN
  // Without the prefix feature x/X is just another invalid character.
  logic unused_is_x;
  assign unused_is_x = is_x;
`endif

  assign accept = ascii_valid && (state_q != ST_HOLD);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      word_q      <= '0;
      cnt_q       <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
`ifdef ASCII_HEX_PREFIX_EN
      prefix_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      shift_q     <= shift_d;
      word_q      <= word_d;
      cnt_q       <= cnt_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
`ifdef ASCII_HEX_PREFIX_EN
      prefix_q    <= prefix_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    word_d      = word_q;
    cnt_d       = cnt_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
`ifdef ASCII_HEX_PREFIX_EN
    prefix_d    = prefix_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          if (is_digit) begin
            if (cnt_q == CNT_W'(NUM_DIGITS)) begin
              err_pulse_d = 1'b1;
              err_code_d  = ERR_OVERFLOW;
              state_d     = ST_SKIP;
            end else begin
              shift_d = (shift_q << 4) | WORD_WIDTH'(nibble);
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = ST_ACCUM;
            end
          end else if (is_term) begin
            // A terminator in IDLE is dropped so no empty words appear.
            if (state_q == ST_ACCUM) begin
`ifdef ASCII_HEX_PREFIX_EN
              if (prefix_q && cnt_q == '0) begin
                err_pulse_d = 1'b1;
                err_code_d  = ERR_EMPTY_PREFIX;
                state_d     = ST_IDLE;
                shift_d     = '0;
                cnt_d       = '0;
                prefix_d    = 1'b0;
              end else begin
                word_d  = shift_q;
                state_d = ST_HOLD;
              end
`else
              word_d  = shift_q;
              state_d = ST_HOLD;
`endif
            end
          end
`ifdef ASCII_HEX_PREFIX_EN
          // "0x": the lone leading zero is the prefix, not a digit.
          else if (is_x && state_q == ST_ACCUM && cnt_q == CNT_W'(1) &&
                   shift_q == '0 && !prefix_q) begin
            cnt_d    = '0;
            prefix_d = 1'b1;
          end
`endif
          else begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_INVALID;
            state_d     = ST_SKIP;
          end
        end
      end

      ST_HOLD: begin
        if (word_ready) begin
          state_d  = ST_IDLE;
          shift_d  = '0;
          cnt_d    = '0;
`ifdef ASCII_HEX_PREFIX_EN
          prefix_d = 1'b0;
`endif
        end
      end

      ST_SKIP: begin
        if (accept && is_term) begin
          state_d  = ST_IDLE;
          shift_d  = '0;
          cnt_d    = '0;
`ifdef ASCII_HEX_PREFIX_EN
          prefix_d = 1'b0;
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ascii_ready = (state_q != ST_HOLD);
    word_valid  = (state_q == ST_HOLD);
  end

  assign word_data   = word_q;
  assign digit_count = cnt_q;
  assign err_pulse   = err_pulse_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_ascii_hex_word_parser.sv
// Directed self-checking bench for ascii_hex_word_parser (NUM_DIGITS=8);
// follows the ASCII_HEX_PREFIX_EN define of the build.
module tb_ascii_hex_word_parser;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ascii_valid = 1'b0;
  logic [7:0]  ascii_data = 8'h00;
  logic        word_ready = 1'b0;
  logic        ascii_ready;
  logic        word_valid;
  logic [31:0] word_data;
  logic [3:0]  digit_count;
  logic        err_pulse;
  logic [1:0]  err_code;

  int total = 0;
  int bad   = 0;

  // Event monitor, sampled on the falling edge.
  int          words_taken = 0;
  int          wv_cycles   = 0;
  int          err_seen    = 0;
  logic [31:0] last_word   = '0;
  logic [3:0]  last_cnt    = '0;
  logic [1:0]  last_err    = '0;

  ascii_hex_word_parser #(.NUM_DIGITS(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ascii_valid (ascii_valid),
    .ascii_data  (ascii_data),
    .ascii_ready (ascii_ready),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .word_ready  (word_ready),
    .digit_count (digit_count),
    .err_pulse   (err_pulse),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (word_valid) begin
      wv_cycles++;
      if (word_ready) begin
        words_taken++;
        last_word = word_data;
        last_cnt  = digit_count;
      end
    end
    if (err_pulse) begin
      err_seen++;
      last_err = err_code;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one character and hold it until the handshake completes.
  task automatic send_char(input logic [7:0] c);
    int n = 0;
    ascii_valid = 1'b1;
    ascii_data  = c;
    while (n < 20) begin
      @(negedge clk);
      if (ascii_ready) break;
      n++;
    end
    @(posedge clk);
    #1;
    ascii_valid = 1'b0;
    check("accept_in_time", 64'(n < 20), 64'd1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  int w0, e0, v0;

  initial begin
    // Reset state
    #1;
    check("rst_ascii_ready", ascii_ready, 1);
    check("rst_word_valid",  word_valid, 0);
    check("rst_word_data",   word_data, 0);
    check("rst_digit_count", digit_count, 0);
    check("rst_err_pulse",   err_pulse, 0);
    check("rst_err_code",    err_code, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(1);

    // "1A2b\n" with consumer always ready
    word_ready = 1'b1;
    v0 = wv_cycles; w0 = words_taken;
    send_str("1A2b");
    check("cnt_after_1a2b", digit_count, 4);
    send_char(8'h0A);
    idle(3);
    check("wv_one_cycle",   wv_cycles - v0, 1);
    check("words_1a2b",     words_taken - w0, 1);
    check("word_1a2b",      last_word, 32'h0000_1A2B);
    check("cnt_word_1a2b",  last_cnt, 4);

    // Exactly NUM_DIGITS digits is still legal
    w0 = words_taken;
    send_str("FFFFFFFF");
    send_char(8'h0A);
    idle(3);
    check("words_full",     words_taken - w0, 1);
    check("word_full",      last_word, 32'hFFFF_FFFF);
    check("cnt_full",       last_cnt, 8);

    // Terminators in IDLE are ignored
    w0 = words_taken; e0 = err_seen;
    send_str(" , ");
    send_char(8'h0D);
    idle(2);
    check("idle_term_words", words_taken - w0, 0);
    check("idle_term_errs",  err_seen - e0, 0);
    check("idle_term_cnt",   digit_count, 0);

    // Overflow on the ninth digit, then recovery
    w0 = words_taken; e0 = err_seen;
    send_str("12345678");
    check("cnt_eight",      digit_count, 8);
    send_char("9");
    check("ovf_pulse",      err_pulse, 1);
    check("ovf_code",       err_code, 2'b10);
    idle(1);
    check("ovf_pulse_once", err_pulse, 0);
    check("ovf_code_held",  err_code, 2'b10);
    send_str(",5 ");
    idle(3);
    check("ovf_words",      words_taken - w0, 1);
    check("ovf_errs",       err_seen - e0, 1);
    check("word_5",         last_word, 32'h0000_0005);
    check("cnt_5",          last_cnt, 1);

    // Invalid character drops the word, next word is clean
    w0 = words_taken; e0 = err_seen;
    send_str("12G");
    check("inv_pulse",      err_pulse, 1);
    check("inv_code",       err_code, 2'b01);
    send_str("4 7");
    send_char(8'h0D);
    idle(3);
    check("inv_words",      words_taken - w0, 1);
    check("inv_errs",       err_seen - e0, 1);
    check("word_7",         last_word, 32'h0000_0007);

    // Back-pressure: word held, "C" waits for the handshake
    word_ready = 1'b0;
    w0 = words_taken;
    send_str("AB");
    send_char(8'h0A);
    ascii_valid = 1'b1;
    ascii_data  = "C";
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ascii_ready", ascii_ready, 0);
      check("bp_word_valid",  word_valid, 1);
      check("bp_word_data",   word_data, 32'h0000_00AB);
      check("bp_digit_count", digit_count, 2);
    end
    @(posedge clk);
    #1;
    word_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hs_word_valid",  word_valid, 0);
    check("hs_ascii_ready", ascii_ready, 1);
    check("hs_cnt_clear",   digit_count, 0);
    @(posedge clk);
    #1;
    ascii_valid = 1'b0;
    check("c_consumed",     digit_count, 1);
    send_char(8'h0A);
    idle(3);
    check("bp_words",       words_taken - w0, 2);
    check("word_c",         last_word, 32'h0000_000C);
    check("cnt_c",          last_cnt, 1);

    // Hex prefix
`ifdef ASCII_HEX_PREFIX_EN
    w0 = words_taken;
    send_str("0xFF");
    send_char(8'h0A);
    idle(3);
    check("pfx_words",      words_taken - w0, 1);
    check("word_ff",        last_word, 32'h0000_00FF);
    check("cnt_ff",         last_cnt, 2);
    w0 = words_taken; e0 = err_seen;
    send_str("0x");
    check("pfx_cnt_zero",   digit_count, 0);
    send_char(8'h0A);
    idle(3);
    check("pfx_empty_errs", err_seen - e0, 1);
    check("pfx_empty_code", last_err, 2'b11);
    check("pfx_empty_word", words_taken - w0, 0);
`else
    w0 = words_taken; e0 = err_seen;
    send_str("0x");
    check("nopfx_pulse",    err_pulse, 1);
    check("nopfx_code",     err_code, 2'b01);
    send_char(8'h0A);
    idle(3);
    check("nopfx_errs",     err_seen - e0, 1);
    check("nopfx_words",    words_taken - w0, 0);
`endif

    // Reset in the middle of a word
    send_str("AB");
    check("mid_cnt",        digit_count, 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid",  word_valid, 0);
    check("mid_rst_ready",  ascii_ready, 1);
    check("mid_rst_cnt",    digit_count, 0);
    check("mid_rst_data",   word_data, 0);
    check("mid_rst_code",   err_code, 0);
    idle(2);
    @(negedge clk);
    reset_n = 1'b1;
    v0 = wv_cycles; w0 = words_taken;
    idle(3);
    check("mid_no_word",    wv_cycles - v0, 0);
    send_str("3");
    send_char(8'h0A);
    idle(3);
    check("mid_words",      words_taken - w0, 1);
    check("word_3",         last_word, 32'h0000_0003);
    check("cnt_3",          last_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
